ctrl_fsm_8085_multi: RTL and testbench
======================================

Name: ctrl_fsm_8085_multi

Overview:
Main multi-cycle control FSM for the 8085-style multi-cycle processor. Sequences fetch, decode, execute, memory and writeback; drives datapath enables, mux selects and the 1-bit ALUop override consumed by the ALU control decoder (ALUop=1 forces ADD for PC increment and address calculation). Also counts retired instructions and holds the core in HALT.

Parameters:
CNT_W, 16, width of retired-instruction counter
HALT_OPC, 5'b10101, opcode that enters HALT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  5  IR[opcode] field, valid from DECODE onward
funct  in  5  IR[funct] field (decode only; passed through, not interpreted here)
zero  in  1  ALU zero flag, valid in BRANCH
mem_ready  in  1  memory handshake; a memory access completes on a cycle with mem_ready=1
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
pc_source  out  2  00 ALU result, 01 ALUOut reg, 10 jump target, 11 interrupt vector
ir_write  out  1  latch instruction register
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
iord  out  1  0 address=PC, 1 address=ALUOut
reg_write  out  1  register-file write
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
alu_src_a  out  1  0 PC, 1 reg A
alu_src_b  out  2  00 reg B, 01 const 1, 10 imm, 11 imm (branch offset)
ALUop  out  1  1 forces ADD in ALU control
illegal  out  1  one-cycle pulse on undecodable opcode
halted  out  1  high while in HALT
instr_count  out  CNT_W  retired-instruction count, wraps

Behaviour:
- Reset (async, rst=1): state=FETCH; all outputs 0 except ALUop=1; instr_count=0.
- Outputs are Moore decodes of state (registered state only); illegal and instr_count are registered.
- FETCH: mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, ALUop=1, pc_source=00. While mem_ready=0, stay in FETCH with ir_write and pc_write held 0. pc_write=1 only on the cycle mem_ready=1 -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ALUop=1 (branch target precompute). Next by opcode: 0-3 -> EXEC_R; 4-12, 15-18 -> EXEC_I; 13 -> MEM_ADDR (load); 14 -> MEM_ADDR (store); 19 -> JUMP; 20 -> BRANCH; HALT_OPC -> HALT; others -> FETCH with illegal=1 for one cycle, instr_count unchanged.
- EXEC_R: alu_src_a=1, alu_src_b=00, ALUop=0 -> ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10, ALUop=0. Opcode 12 (compare) -> FETCH, retired, no writeback; else -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 for opcode 0-3 else 0 -> FETCH, retired.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUop=1 -> MEM_RD (load) or MEM_WR (store).
- MEM_RD: mem_read=1, iord=1; wait for mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH, retired.
- MEM_WR: mem_write=1, iord=1; wait for mem_ready -> FETCH, retired.
- BRANCH: alu_src_a=1, alu_src_b=00, ALUop=0, pc_write_cond=1, pc_source=01 -> FETCH, retired.
- JUMP: pc_write=1, pc_source=10 -> FETCH, retired.
- HALT: halted=1, all strobes 0; exits only by reset. The instruction is counted as retired on entry.
- Retire: instr_count increments by 1 on the transition into FETCH marked retired; it wraps from all-ones to 0.
- Latency: R-type 4 cycles, compare 3, load 5, store 4, branch/jump 3 (each memory access +N wait cycles).
- rst asserted mid-access drops mem_read/mem_write in the same cycle (async).

Optional Feature:
CTRL_INTR_EN: adds ports intr (in, 1) and intr_ack (out, 1), plus state INTR. With the macro, FETCH entry with intr=1 and no access in progress goes to INTR instead: pc_write=1, pc_source=11, intr_ack=1 for one cycle -> FETCH. INTR is not counted as retired. HALT exits to INTR on intr=1. Without the macro, neither port nor state exists and pc_source=11 is never driven.

Decomposition:
- Package ctrl_8085_pkg: state enum, opcode class constants (OPC_LOAD=13, OPC_STORE=14, OPC_CMP=12, OPC_JMP=19, OPC_BEQ=20), pc_source and alu_src_b encodings.
- Optional sub-module: instr_retire_counter (CNT_W-bit wrapping counter with enable).

Test Plan:
- Reset mid-MEM_RD (mem_read=1), assert rst -> mem_read=0 immediately, state=FETCH, instr_count=0, ALUop=1.
- R-type opcode=0, funct=0, mem_ready=1 always -> exactly 4 cycles FETCH/DECODE/EXEC_R/ALU_WB; reg_write=1, reg_dst=1 in cycle 4; instr_count 0->1.
- Load opcode=13 with mem_ready low for 3 cycles in MEM_RD -> mem_read and iord held high; MEM_WB follows, with mem_to_reg=1 and reg_write=1; total 8 cycles.
- Branch opcode=20 with zero=1 and then zero=0 -> pc_write_cond=1, pc_source=01 in BRANCH both times; 3 cycles each; instr_count +2.
- Opcode 5'b11111 -> illegal pulses for 1 cycle, back in FETCH, instr_count unchanged; HALT_OPC -> halted=1 stays high 20 cycles, no strobes.
- With CTRL_INTR_EN, intr=1 while halted -> intr_ack=1 and pc_source=11 for one cycle, then FETCH.

Source files
------------

// File: rtl/ctrl_fsm_8085_multi_pkg.sv
// Shared definitions for the 8085-style multi-cycle control FSM.
// Optional macro CTRL_INTR_EN adds the INTR state.
package ctrl_8085_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_HALT
`ifdef CTRL_INTR_EN
    , S_INTR
`endif
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_JMP, CLS_BEQ, CLS_HALT, CLS_ILL
  } opc_class_t;

  localparam logic [4:0] OPC_CMP   = 5'd12;
  localparam logic [4:0] OPC_LOAD  = 5'd13;
  localparam logic [4:0] OPC_STORE = 5'd14;
  localparam logic [4:0] OPC_JMP   = 5'd19;
  localparam logic [4:0] OPC_BEQ   = 5'd20;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_VEC    = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // HALT is checked first so a reassigned HALT opcode wins over its old class.
  function automatic opc_class_t opc_class(input logic [4:0] opc,
                                           input logic [4:0] halt_opc);
    if (opc == halt_opc)        return CLS_HALT;
    else if (opc <= 5'd3)       return CLS_R;
    else if (opc == OPC_LOAD)   return CLS_LOAD;
    else if (opc == OPC_STORE)  return CLS_STORE;
    else if (opc == OPC_JMP)    return CLS_JMP;
    else if (opc == OPC_BEQ)    return CLS_BEQ;
    else if (opc <= 5'd18)      return CLS_I;
    else                        return CLS_ILL;
  endfunction

endpackage

// File: rtl/ctrl_fsm_8085_multi_if.sv
// Memory-side bus of the control FSM.
// Handshake: the master holds mem_read or mem_write (with iord) high for the
// whole access; the access completes on the first rising edge where the slave
// has mem_ready=1. mem_ready outside an access is ignored.
interface ctrl_fsm_8085_multi_if;
  logic mem_read;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (output mem_read, output mem_write, output iord, input mem_ready);
  modport slave  (input mem_read, input mem_write, input iord, output mem_ready);
endinterface

// File: rtl/ctrl_fsm_8085_multi_counter.sv
// Retired-instruction counter: CNT_W-bit, increments on en, wraps to zero.
module instr_retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count one retirement per enabled cycle; overflow wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= '0;
    else if (en) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign count = r_count;

endmodule

// File: rtl/ctrl_fsm_8085_multi.sv
// Main multi-cycle control FSM: fetch/decode/execute/memory/writeback,
// instruction retire counting and HALT. Optional macro CTRL_INTR_EN adds
// intr/intr_ack and the INTR state (vectored PC load, not retired).
module ctrl_fsm_8085_multi
  import ctrl_8085_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [4:0] HALT_OPC = 5'b10101
) (
  input  logic                 clk,
  input  logic                 rst,
  ctrl_fsm_8085_multi_if.master bus,
  input  logic [4:0]           opcode,
  input  logic [4:0]           funct,
  input  logic                 zero,
`ifdef CTRL_INTR_EN
  input  logic                 intr,
  output logic                 intr_ack,
`endif
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_source,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 ALUop,
  output logic                 illegal,
  output logic                 halted,
  output logic [CNT_W-1:0]     instr_count,
  output state_t               dbg_state
);

  state_t     r_state, w_state_nxt, w_fetch_tgt;
  opc_class_t w_class;
  logic       w_retire, w_illegal_nxt, r_illegal;
  logic       w_unused;

  // funct is decoded by the ALU control block; zero is consumed by the PC
  // write-enable logic outside this FSM.
  assign w_unused = ^{funct, zero};

  assign w_class = opc_class(opcode, HALT_OPC);

`ifdef CTRL_INTR_EN
  // Interrupts are taken only between instructions, before a fetch starts.
  assign w_fetch_tgt = intr ? S_INTR : S_FETCH;
`else
  assign w_fetch_tgt = S_FETCH;
`endif

  // State register plus the registered one-cycle illegal pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  // Next state, retire strobe and Moore control outputs; reset forces idle.
  always_comb begin
    w_state_nxt   = r_state;
    w_retire      = 1'b0;
    w_illegal_nxt = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCS_ALU;
    ir_write      = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.iord      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    ALUop         = 1'b0;
    halted        = 1'b0;
`ifdef CTRL_INTR_EN
    intr_ack      = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        alu_src_b    = SRCB_ONE;
        ALUop        = 1'b1;
        ir_write     = bus.mem_ready;
        pc_write     = bus.mem_ready;
        if (bus.mem_ready) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_BOFF;
        ALUop     = 1'b1;
        case (w_class)
          CLS_R:     w_state_nxt = S_EXEC_R;
          CLS_I:     w_state_nxt = S_EXEC_I;
          CLS_LOAD:  w_state_nxt = S_MEM_ADDR;
          CLS_STORE: w_state_nxt = S_MEM_ADDR;
          CLS_JMP:   w_state_nxt = S_JUMP;
          CLS_BEQ:   w_state_nxt = S_BRANCH;
          CLS_HALT: begin
            w_state_nxt = S_HALT;
            w_retire    = 1'b1;
          end
          default: begin
            w_state_nxt   = w_fetch_tgt;
            w_illegal_nxt = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_REG;
        w_state_nxt = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (opcode == OPC_CMP) begin
          w_state_nxt = w_fetch_tgt;
          w_retire    = 1'b1;
        end else begin
          w_state_nxt = S_ALU_WB;
        end
      end
      S_ALU_WB: begin
        reg_write   = 1'b1;
        reg_dst     = (w_class == CLS_R);
        w_state_nxt = w_fetch_tgt;
        w_retire    = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        ALUop       = 1'b1;
        w_state_nxt = (w_class == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) w_state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write   = 1'b1;
        mem_to_reg  = 1'b1;
        w_state_nxt = w_fetch_tgt;
        w_retire    = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready) begin
          w_state_nxt = w_fetch_tgt;
          w_retire    = 1'b1;
        end
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REG;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
        w_state_nxt   = w_fetch_tgt;
        w_retire      = 1'b1;
      end
      S_JUMP: begin
        pc_write    = 1'b1;
        pc_source   = PCS_JUMP;
        w_state_nxt = w_fetch_tgt;
        w_retire    = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
`ifdef CTRL_INTR_EN
        if (intr) w_state_nxt = S_INTR;
`endif
      end
`ifdef CTRL_INTR_EN
      S_INTR: begin
        pc_write    = 1'b1;
        pc_source   = PCS_VEC;
        intr_ack    = 1'b1;
        w_state_nxt = S_FETCH;
      end
`endif
      default: w_state_nxt = S_FETCH;
    endcase
    // Reset drops strobes immediately, even mid-access; ALUop idles at ADD.
    if (rst) begin
      w_retire      = 1'b0;
      w_illegal_nxt = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PCS_ALU;
      ir_write      = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.iord      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      ALUop         = 1'b1;
      halted        = 1'b0;
`ifdef CTRL_INTR_EN
      intr_ack      = 1'b0;
`endif
    end
  end

  instr_retire_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (w_retire),
    .count (instr_count)
  );

  assign illegal   = r_illegal;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ctrl_fsm_8085_multi.sv
// Directed testbench for ctrl_fsm_8085_multi: per-cycle expected control
// words are queued per instruction and compared as the DUT steps through.
// Builds with or without CTRL_INTR_EN. The DUT counter is narrowed to 3 bits
// so the wrap-around is reached with a handful of instructions.
module tb_ctrl_fsm_8085_multi;
  import ctrl_8085_pkg::*;

  localparam int CW = 3;
  localparam int W  = 21;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] opcode = 5'd0;
  logic [4:0] funct = 5'd0;
  logic zero = 1'b0;
`ifdef CTRL_INTR_EN
  logic intr = 1'b0;
  logic intr_ack;
`endif
  logic pc_write, pc_write_cond, ir_write, reg_write, reg_dst, mem_to_reg;
  logic alu_src_a, ALUop, illegal, halted;
  logic [1:0] pc_source, alu_src_b;
  logic [CW-1:0] instr_count;
  state_t dbg_state;

  ctrl_fsm_8085_multi_if bus ();

  ctrl_fsm_8085_multi #(.CNT_W(CW), .HALT_OPC(5'b10101)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
`ifdef CTRL_INTR_EN
    .intr          (intr),
    .intr_ack      (intr_ack),
`endif
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .ALUop         (ALUop),
    .illegal       (illegal),
    .halted        (halted),
    .instr_count   (instr_count),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] obs;
  assign obs = {dbg_state, pc_write, pc_write_cond, pc_source, ir_write,
                bus.mem_read, bus.mem_write, bus.iord, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, ALUop, illegal, halted};

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt = '0;

  // Control word required by the state table for one cycle.
  function automatic logic [W-1:0] exp_word(input state_t s, input logic [4:0] opc,
                                            input logic rdy, input logic ill);
    logic pcw, pcwc, irw, mr, mw, io, rw, rd, m2r, sa, alu, hlt;
    logic [1:0] pcs, sb;
    {pcw, pcwc, irw, mr, mw, io, rw, rd, m2r, sa, alu, hlt} = '0;
    pcs = 2'b00;
    sb  = 2'b00;
    case (s)
      S_FETCH:    begin mr = 1; irw = rdy; pcw = rdy; sb = 2'b01; alu = 1; end
      S_DECODE:   begin sb = 2'b11; alu = 1; end
      S_EXEC_R:   begin sa = 1; sb = 2'b00; end
      S_EXEC_I:   begin sa = 1; sb = 2'b10; end
      S_ALU_WB:   begin rw = 1; rd = (opc <= 5'd3); end
      S_MEM_ADDR: begin sa = 1; sb = 2'b10; alu = 1; end
      S_MEM_RD:   begin mr = 1; io = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 1; end
      S_MEM_WR:   begin mw = 1; io = 1; end
      S_BRANCH:   begin sa = 1; pcwc = 1; pcs = 2'b01; end
      S_JUMP:     begin pcw = 1; pcs = 2'b10; end
      S_HALT:     begin hlt = 1; end
`ifdef CTRL_INTR_EN
      S_INTR:     begin pcw = 1; pcs = 2'b11; end
`endif
      default:    begin end
    endcase
    return {s, pcw, pcwc, pcs, irw, mr, mw, io, rw, rd, m2r, sa, sb, alu, ill, hlt};
  endfunction

  localparam logic [W-1:0] RST_WORD = {S_FETCH, 12'b0, 2'b00, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // driver tasks
  task automatic plan(input state_t s, input logic rdy, input logic ill = 1'b0);
    exp_q.push_back(exp_word(s, opcode, rdy, ill));
    rdy_q.push_back(rdy);
  endtask

  task automatic drain(input string tag);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      bus.mem_ready = rdy_q.pop_front();
      #1;
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // One idle FETCH cycle, then compare the retire count.
  task automatic check_cnt(input string tag);
    plan(S_FETCH, 1'b0);
    drain({tag, "_idle"});
    chk(tag, W'(instr_count), W'(exp_cnt));
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    #2;
    chk("reset_word", obs, RST_WORD);
    chk("reset_cnt", W'(instr_count), W'(0));
    @(negedge clk);
    rst = 1'b0;

    // R-type: 4 cycles, rd destination
    opcode = 5'd0; funct = 5'd0;
    plan(S_FETCH, 1); plan(S_DECODE, 1); plan(S_EXEC_R, 1); plan(S_ALU_WB, 1);
    drain("rtype"); exp_cnt++; check_cnt("rtype_cnt");

    // I-type: rt destination
    opcode = 5'd7; funct = 5'($urandom_range(0, 31));
    plan(S_FETCH, 1); plan(S_DECODE, 1); plan(S_EXEC_I, 1); plan(S_ALU_WB, 1);
    drain("itype"); exp_cnt++; check_cnt("itype_cnt");

    // compare: 3 cycles, no writeback
    opcode = OPC_CMP;
    plan(S_FETCH, 1); plan(S_DECODE, 1); plan(S_EXEC_I, 1);
    drain("cmp"); exp_cnt++; check_cnt("cmp_cnt");

    // load with 3 wait cycles in MEM_RD: 8 cycles
    opcode = OPC_LOAD;
    plan(S_FETCH, 1); plan(S_DECODE, 1); plan(S_MEM_ADDR, 1);
    plan(S_MEM_RD, 0); plan(S_MEM_RD, 0); plan(S_MEM_RD, 0); plan(S_MEM_RD, 1);
    plan(S_MEM_WB, 1);
    drain("load"); exp_cnt++; check_cnt("load_cnt");

    // store with one fetch wait and one write wait
    opcode = OPC_STORE;
    plan(S_FETCH, 0); plan(S_FETCH, 1); plan(S_DECODE, 1); plan(S_MEM_ADDR, 1);
    plan(S_MEM_WR, 0); plan(S_MEM_WR, 1);
    drain("store"); exp_cnt++; check_cnt("store_cnt");

    // branch taken and not taken
    opcode = OPC_BEQ; zero = 1'b1;
    plan(S_FETCH, 1); plan(S_DECODE, 1); plan(S_BRANCH, 1);
    drain("beq_z1"); exp_cnt++; check_cnt("beq_z1_cnt");
    zero = 1'b0;
    plan(S_FETCH, 1); plan(S_DECODE, 1); plan(S_BRANCH, 1);
    drain("beq_z0"); exp_cnt++; check_cnt("beq_z0_cnt");

    // jump: eighth retirement wraps the 3-bit counter to 0
    opcode = OPC_JMP;
    plan(S_FETCH, 1); plan(S_DECODE, 1); plan(S_JUMP, 1);
    drain("jmp"); exp_cnt++; check_cnt("wrap_cnt");

    // illegal opcode: one-cycle pulse, count unchanged
    opcode = 5'b11111;
    plan(S_FETCH, 1); plan(S_DECODE, 1); plan(S_FETCH, 0, 1'b1);
    drain("illegal"); check_cnt("illegal_cnt");

    opcode = OPC_JMP;
    plan(S_FETCH, 1); plan(S_DECODE, 1); plan(S_JUMP, 1);
    drain("jmp2"); exp_cnt++; check_cnt("jmp2_cnt");

    // reset asserted mid-MEM_RD
    opcode = OPC_LOAD;
    plan(S_FETCH, 1); plan(S_DECODE, 1); plan(S_MEM_ADDR, 1); plan(S_MEM_RD, 0);
    drain("load_pre_rst");
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("mem_read_before_rst", W'(bus.mem_read), W'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_word", obs, RST_WORD);
    chk("rst_mid_cnt", W'(instr_count), W'(0));
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;

    // HALT: retired on entry, held for 20 cycles with no strobes
    opcode = 5'b10101;
    plan(S_FETCH, 1); plan(S_DECODE, 1);
    for (int i = 0; i < 20; i++) plan(S_HALT, 1);
    drain("halt");
    exp_cnt++;
    chk("halt_cnt", W'(instr_count), W'(exp_cnt));

`ifdef CTRL_INTR_EN
    // interrupt while halted: one INTR cycle, then FETCH, not retired
    @(negedge clk);
    bus.mem_ready = 1'b0; intr = 1'b1;
    #1;
    chk("intr_req_halt", obs, exp_word(S_HALT, opcode, 0, 0));
    @(negedge clk);
    intr = 1'b0;
    #1;
    chk("intr_state", obs, exp_word(S_INTR, opcode, 0, 0));
    chk("intr_ack_hi", W'(intr_ack), W'(1));
    @(negedge clk);
    #1;
    chk("intr_ret", obs, exp_word(S_FETCH, opcode, 0, 0));
    chk("intr_ack_lo", W'(intr_ack), W'(0));
    chk("intr_cnt", W'(instr_count), W'(exp_cnt));
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
